// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: owns the fetch PC, requests words from instruction memory,
// buffers them in a small prefetch FIFO and presents {pc, inst} to decode.
module pipe_if_stage #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    output logic                     imem_req_o,
    output logic [31:0]              imem_addr_o,
    input  logic                     imem_ready_i,
    input  logic [31:0]              imem_rdata_i,
    input  logic                     br_redirect_i,
    input  logic [31:0]              br_target_i,
    input  logic                     id_stall_i,
    output logic                     id_valid_o,
    output logic [31:0]              id_inst_o,
    output logic [31:0]              id_pc_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [31:0]      fetchPc_q, fetchPc_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] pcMem_q   [DEPTH];
    logic [31:0] instMem_q [DEPTH];

    logic fifoEmpty;
    logic fifoFull;
    logic push;
    logic pop;

    // Request depends only on registered state, reset and redirect, never on stall/ready.
    always_comb begin
        fifoEmpty  = (count_q == '0);
        fifoFull   = (count_q == FULL_COUNT);
        imem_req_o = !rst_i && !br_redirect_i && !fifoFull;
        push       = imem_req_o && imem_ready_i;
        pop        = !fifoEmpty && !id_stall_i && !br_redirect_i && !rst_i;
    end

    assign imem_addr_o = fetchPc_q;

    always_comb begin
        fetchPc_d = fetchPc_q;
        rdPtr_d   = rdPtr_q;
        wrPtr_d   = wrPtr_q;
        count_d   = count_q;
        if (br_redirect_i) begin
            fetchPc_d = br_target_i & 32'hFFFF_FFFC;
            rdPtr_d   = '0;
            wrPtr_d   = '0;
            count_d   = '0;
        end else begin
            if (push) begin
                fetchPc_d = fetchPc_q + 32'd4;
                wrPtr_d   = wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetchPc_q <= RESET_PC;
            rdPtr_q   <= '0;
            wrPtr_q   <= '0;
            count_q   <= '0;
        end else begin
            fetchPc_q <= fetchPc_d;
            rdPtr_q   <= rdPtr_d;
            wrPtr_q   <= wrPtr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pcMem_q[wrPtr_q]   <= fetchPc_q;
            instMem_q[wrPtr_q] <= imem_rdata_i;
        end
    end

    always_comb begin
        id_valid_o   = !fifoEmpty;
        id_inst_o    = fifoEmpty ? NOP   : instMem_q[rdPtr_q];
        id_pc_o      = fifoEmpty ? 32'h0 : pcMem_q[rdPtr_q];
        fifo_count_o = count_q;
    end

endmodule

// File: tb/tb_pipe_if_stage.sv
// Scoreboard bench for pipe_if_stage: accepted fetches are queued with their expected
// {pc, inst}, and the queue head is compared against the decode-side outputs every cycle.
module tb_pipe_if_stage;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemReady = 1'b0;
    logic [31:0] imemRdata = 32'h0;
    logic        brRedirect = 1'b0;
    logic [31:0] brTarget = 32'h0;
    logic        idStall = 1'b0;
    logic        idValid;
    logic [31:0] idInst;
    logic [31:0] idPc;
    logic [2:0]  fifoCount;

    int          total = 0;
    int          bad = 0;
    logic [63:0] sb[$];
    logic [31:0] mPc = RESET_PC;
    string       phase = "init";

    pipe_if_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_req_o   (imemReq),
        .imem_addr_o  (imemAddr),
        .imem_ready_i (imemReady),
        .imem_rdata_i (imemRdata),
        .br_redirect_i(brRedirect),
        .br_target_i  (brTarget),
        .id_stall_i   (idStall),
        .id_valid_o   (idValid),
        .id_inst_o    (idInst),
        .id_pc_o      (idPc),
        .fifo_count_o (fifoCount)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs.
    task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s %s: got %h want %h", phase, tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, check outputs against the model, then advance the model.
    task applyStimulus(input logic r, input logic rdy, input logic st,
                       input logic br, input logic [31:0] tgt);
        logic        mReq;
        logic        mValid;
        logic [63:0] head;
        @(negedge clk);
        rst        = r;
        imemReady  = rdy;
        idStall    = st;
        brRedirect = br;
        brTarget   = tgt;
        imemRdata  = mPc ^ KEY;
        #1;
        mReq   = !r && !br && (sb.size() < DEPTH);
        mValid = (sb.size() != 0);
        checkOutput("imem_req", {31'b0, imemReq}, {31'b0, mReq});
        if (!r) begin
            checkOutput("imem_addr", imemAddr, mPc);
            checkOutput("fifo_count", 32'(fifoCount), 32'(sb.size()));
            checkOutput("id_valid", {31'b0, idValid}, {31'b0, mValid});
            if (mValid) begin
                head = sb[0];
                checkOutput("id_pc", idPc, head[63:32]);
                checkOutput("id_inst", idInst, head[31:0]);
            end else begin
                checkOutput("id_pc_empty", idPc, 32'h0);
                checkOutput("id_inst_empty", idInst, NOP);
            end
        end
        if (r) begin
            mPc = RESET_PC;
            sb.delete();
        end else if (br) begin
            mPc = tgt & 32'hFFFF_FFFC;
            sb.delete();
        end else begin
            if (mValid && !st) void'(sb.pop_front());
            if (mReq && rdy) begin
                sb.push_back({mPc, mPc ^ KEY});
                mPc = mPc + 32'd4;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        phase = "t1";
        repeat (2) applyStimulus(1, 1, 0, 0, 0);
        repeat (8) applyStimulus(0, 1, 0, 0, 0);

        phase = "t2";
        applyStimulus(1, 1, 1, 0, 0);
        repeat (6) applyStimulus(0, 1, 1, 0, 0);
        repeat (8) applyStimulus(0, 1, 0, 0, 0);

        phase = "t3";
        applyStimulus(1, 1, 1, 0, 0);
        repeat (3) applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 1, 32'h0000_0100);
        repeat (3) applyStimulus(0, 1, 0, 0, 0);

        phase = "t4";
        applyStimulus(0, 1, 0, 1, 32'h0000_0103);
        repeat (3) applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 1, 32'hFFFF_FFFC);
        repeat (4) applyStimulus(0, 1, 0, 0, 0);

        phase = "t5";
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, (i % 2) == 0, 0, 0, 0);

        phase = "t6";
        applyStimulus(1, 1, 1, 0, 0);
        repeat (2) applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        repeat (5) applyStimulus(0, 1, 0, 0, 0);

        phase = "rand";
        for (int i = 0; i < 60; i++) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 11) == 0), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
